lsu_bus_if: RTL and testbench

Load/store unit sitting directly downstream of the core's ALU/controller data-memory port. It replaces the zero-latency data_mem hookup with a request/acknowledge bus of variable latency.
- Takes addr (ALU result), mem_acc_mode (funct3), store data (rs2) and rd_en/wr_en.
- Generates the word-aligned bus address, byte enables and lane-replicated write data.
- Stalls the core until the access completes.
- Returns sign- or zero-extended load data to the writeback mux.

---
 rtl/lsu_bus_if.sv | 154 +++++++++++++++
 tb/tb_lsu_bus_if.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_if.sv
// Load/store unit: turns the core's zero-latency data-memory port into a
// variable-latency request/ack bus access, stalling the core until it completes.
module lsu_bus_if #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [31:0] addr,
   input  logic [2:0]  mem_acc_mode,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        load_misalign,
   output logic        store_misalign,
   output logic        bus_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   input  logic        bus_err_in
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_addr;
   logic [2:0]    r_mode;
   logic          r_we;
   logic [31:0]   r_wdata;
   logic [31:0]   r_rdata;
   logic          r_err;

   logic          w_req, w_misalign, w_timeout, w_start;
   logic          w_in_is_w, w_in_is_h, w_is_w, w_is_h, w_signed;
   logic [3:0]    w_be;
   logic [31:0]   w_wdata, w_lane, w_ext;

   // Modes 011/110/111 have bit 1 set and therefore fall into the word class.
   assign w_in_is_w  = mem_acc_mode[1];
   assign w_in_is_h  = ~mem_acc_mode[1] & mem_acc_mode[0];
   assign w_req      = rd_en | wr_en;
   assign w_misalign = (w_in_is_w & (addr[1:0] != 2'b00)) | (w_in_is_h & addr[0]);
   assign w_start    = (r_state == S_IDLE) & w_req & ~w_misalign;
   assign w_timeout  = (r_cnt == CNT_LAST);

   assign w_is_w   = r_mode[1];
   assign w_is_h   = ~r_mode[1] & r_mode[0];
   assign w_signed = ~r_mode[2];
   assign w_lane   = r_rdata >> {r_addr[1:0], 3'b000};

   always_comb begin
      w_be    = 4'b0001 << r_addr[1:0];
      w_wdata = {4{r_wdata[7:0]}};
      w_ext   = {{24{w_signed & w_lane[7]}}, w_lane[7:0]};
      if (w_is_w) begin
         w_be    = 4'b1111;
         w_wdata = r_wdata;
         w_ext   = r_rdata;
      end else if (w_is_h) begin
         w_be    = 4'b0011 << {r_addr[1], 1'b0};
         w_wdata = {2{r_wdata[15:0]}};
         w_ext   = {{16{w_signed & w_lane[15]}}, w_lane[15:0]};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Outputs are gated on rst so that a held request cannot raise stall or a
   // misalign pulse while the block is in reset.
   always_comb begin
      w_state_nxt    = r_state;
      stall          = 1'b0;
      load_misalign  = 1'b0;
      store_misalign = 1'b0;
      bus_err        = 1'b0;
      bus_req        = 1'b0;
      bus_we         = 1'b0;
      bus_addr       = '0;
      bus_be         = '0;
      bus_wdata      = '0;
      rdata          = '0;
      case (r_state)
         S_IDLE: begin
            if (rst && w_req) begin
               if (w_misalign) begin
                  store_misalign = wr_en;
                  load_misalign  = ~wr_en;
               end else begin
                  stall       = 1'b1;
                  w_state_nxt = S_ACCESS;
               end
            end
         end
         S_ACCESS: begin
            stall     = 1'b1;
            bus_req   = 1'b1;
            bus_we    = r_we;
            bus_addr  = {r_addr[31:2], 2'b00};
            bus_be    = w_be;
            bus_wdata = w_wdata;
            if (bus_ack || w_timeout) w_state_nxt = S_RESP;
         end
         S_RESP: begin
            bus_err     = r_err;
            rdata       = (r_we || r_err) ? '0 : w_ext;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt   <= '0;
         r_addr  <= '0;
         r_mode  <= '0;
         r_we    <= 1'b0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else if (w_start) begin
         r_addr  <= addr;
         r_mode  <= mem_acc_mode;
         r_we    <= wr_en;
         r_wdata <= wdata;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else if (r_state == S_ACCESS) begin
         if (bus_ack) begin
            r_rdata <= bus_rdata;
            r_err   <= bus_err_in;
            r_cnt   <= '0;
         end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_cnt   <= '0;
         end else begin
            r_cnt   <= r_cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_lsu_bus_if.sv
// Self-checking bench for lsu_bus_if: directed scenarios plus randomized
// accesses checked against a byte-lane arithmetic model of the access rules.
module tb_lsu_bus_if;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_en, wr_en;
   logic [31:0] addr;
   logic [2:0]  mem_acc_mode;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        stall, load_misalign, store_misalign, bus_err;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        bus_err_in;

   int n_tests = 0;
   int n_fail  = 0;

   lsu_bus_if #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
      .mem_acc_mode(mem_acc_mode), .wdata(wdata), .rdata(rdata), .stall(stall),
      .load_misalign(load_misalign), .store_misalign(store_misalign),
      .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
      .bus_rdata(bus_rdata), .bus_err_in(bus_err_in)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Drives one core access and checks every cycle of it. Called just after a
   // rising edge; returns just after a rising edge with the core idle.
   task automatic do_access(input string tag, input bit wr, input bit rd,
                            input logic [2:0] mode, input logic [31:0] a,
                            input logic [31:0] wd, input int unsigned ack_dly,
                            input logic [31:0] brd, input bit berr, input bit drop_req);
      int unsigned size, off, n_acc;
      logic [31:0] exp_be32, exp_wd, exp_rd, mask, lane;
      bit mis, to, exp_err, is_st;
      is_st = wr;
      size  = mode[1] ? 4 : (mode[0] ? 2 : 1);
      off   = a[1:0];
      mis   = (off % size) != 0;
      exp_be32 = ((32'd1 << size) - 32'd1) << off;
      if (size == 1)      exp_wd = {24'd0, wd[7:0]} * 32'h01010101;
      else if (size == 2) exp_wd = {16'd0, wd[15:0]} * 32'h00010001;
      else                exp_wd = wd;
      to      = ack_dly >= TO;
      n_acc   = to ? TO : ack_dly + 1;
      exp_err = to || berr;
      lane    = brd >> (8 * off);
      if (size < 4) begin
         mask = (32'd1 << (8 * size)) - 32'd1;
         lane = lane & mask;
         if (!mode[2] && lane[8*size-1]) lane = lane | ~mask;
      end
      exp_rd = (is_st || exp_err) ? 32'd0 : lane;

      wr_en = wr; rd_en = rd; mem_acc_mode = mode; addr = a; wdata = wd;
      bus_ack = 1'b0; bus_rdata = $urandom; bus_err_in = 1'b0;
      @(negedge clk);
      n_tests++;
      if (stall !== !mis) begin
         n_fail++; $display("FAIL %s idle_stall: got %b exp %b", tag, stall, !mis);
      end
      n_tests++;
      if (bus_req !== 1'b0) begin
         n_fail++; $display("FAIL %s idle_bus_req: got %b exp 0", tag, bus_req);
      end
      n_tests++;
      if (load_misalign !== (mis && !is_st) || store_misalign !== (mis && is_st)) begin
         n_fail++;
         $display("FAIL %s misalign: got ld=%b st=%b exp ld=%b st=%b", tag,
                  load_misalign, store_misalign, mis && !is_st, mis && is_st);
      end
      if (mis) begin
         @(posedge clk); #1;
         wr_en = 1'b0; rd_en = 1'b0;
         @(negedge clk);
         n_tests++;
         if (bus_req !== 1'b0 || stall !== 1'b0 || load_misalign !== 1'b0 || store_misalign !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_misalign: got req=%b stall=%b ld=%b st=%b exp all 0", tag,
                     bus_req, stall, load_misalign, store_misalign);
         end
         @(posedge clk); #1;
         return;
      end
      for (int unsigned k = 0; k < n_acc; k++) begin
         @(posedge clk); #1;
         if (drop_req && k == 0) begin wr_en = 1'b0; rd_en = 1'b0; end
         bus_ack = (k == ack_dly);
         bus_rdata = (k == ack_dly) ? brd : $urandom;
         bus_err_in = (k == ack_dly) ? berr : 1'($urandom_range(0, 1));
         @(negedge clk);
         n_tests++;
         if (bus_req !== 1'b1 || stall !== 1'b1) begin
            n_fail++; $display("FAIL %s access%0d: got req=%b stall=%b exp 1 1", tag, k, bus_req, stall);
         end
         n_tests++;
         if (bus_we !== is_st || bus_addr !== {a[31:2], 2'b00}) begin
            n_fail++;
            $display("FAIL %s bus_we_addr%0d: got %b %h exp %b %h", tag, k, bus_we, bus_addr,
                     is_st, {a[31:2], 2'b00});
         end
         n_tests++;
         if (bus_be !== exp_be32[3:0] || bus_wdata !== exp_wd) begin
            n_fail++;
            $display("FAIL %s be_wdata%0d: got %b %h exp %b %h", tag, k, bus_be, bus_wdata,
                     exp_be32[3:0], exp_wd);
         end
      end
      // ack and error noise during RESP must have no effect
      @(posedge clk); #1;
      bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom; bus_err_in = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_tests++;
      if (stall !== 1'b0 || bus_req !== 1'b0) begin
         n_fail++; $display("FAIL %s resp_ctrl: got stall=%b req=%b exp 0 0", tag, stall, bus_req);
      end
      n_tests++;
      if (bus_err !== exp_err) begin
         n_fail++; $display("FAIL %s bus_err: got %b exp %b", tag, bus_err, exp_err);
      end
      n_tests++;
      if (rdata !== exp_rd) begin
         n_fail++; $display("FAIL %s rdata: got %h exp %h", tag, rdata, exp_rd);
      end
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0; bus_ack = 1'b0; bus_err_in = 1'b0;
      @(negedge clk);
      n_tests++;
      if (stall !== 1'b0 || bus_req !== 1'b0 || bus_err !== 1'b0 || rdata !== 32'd0) begin
         n_fail++;
         $display("FAIL %s post_idle: got stall=%b req=%b err=%b rdata=%h exp 0", tag,
                  stall, bus_req, bus_err, rdata);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; rd_en = 1'b1; wr_en = 1'b0; addr = 32'h100; mem_acc_mode = 3'b010;
      wdata = 32'h1234_5678; bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF; bus_err_in = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (stall !== 1'b0 || bus_req !== 1'b0 || bus_we !== 1'b0) begin
         n_fail++; $display("FAIL reset_ctrl: got stall=%b req=%b we=%b exp 0", stall, bus_req, bus_we);
      end
      n_tests++;
      if (bus_addr !== 32'd0 || bus_be !== 4'd0 || bus_wdata !== 32'd0 || rdata !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_data: got addr=%h be=%b wd=%h rd=%h exp 0", bus_addr, bus_be, bus_wdata, rdata);
      end
      addr = 32'h101;
      #1;
      n_tests++;
      if (load_misalign !== 1'b0 || store_misalign !== 1'b0 || bus_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_pulses: got ld=%b st=%b err=%b exp 0", load_misalign, store_misalign, bus_err);
      end
      @(posedge clk); #1;
      rd_en = 1'b0; bus_ack = 1'b0; bus_err_in = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_store_word();
      do_access("sw", 1'b1, 1'b0, 3'b010, 32'h100, 32'hDEAD_BEEF, 1, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic test_load_byte();
      do_access("lb",  1'b0, 1'b1, 3'b000, 32'h203, 32'h0, 0, 32'h80FF_1234, 1'b0, 1'b0);
      do_access("lbu", 1'b0, 1'b1, 3'b100, 32'h203, 32'h0, 2, 32'h80FF_1234, 1'b0, 1'b0);
   endtask

   task automatic test_half();
      do_access("sh", 1'b1, 1'b0, 3'b001, 32'h102, 32'h0000_ABCD, 0, 32'h0, 1'b0, 1'b0);
      do_access("lh", 1'b0, 1'b1, 3'b001, 32'h102, 32'h0, 0, 32'h7FFF_0000, 1'b0, 1'b0);
      do_access("lhu", 1'b0, 1'b1, 3'b101, 32'h100, 32'h0, 1, 32'h1234_8001, 1'b0, 1'b0);
   endtask

   task automatic test_misalign();
      do_access("lw_mis", 1'b0, 1'b1, 3'b010, 32'h101, 32'h0, 0, 32'h0, 1'b0, 1'b0);
      do_access("sh_mis", 1'b1, 1'b0, 3'b001, 32'h001, 32'h5555, 0, 32'h0, 1'b0, 1'b0);
      do_access("both_prio", 1'b1, 1'b1, 3'b010, 32'h202, 32'h0, 0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic test_timeout_err();
      do_access("lw_timeout", 1'b0, 1'b1, 3'b010, 32'h300, 32'h0, 100, 32'hCAFE_F00D, 1'b0, 1'b0);
      do_access("lw_last",    1'b0, 1'b1, 3'b010, 32'h304, 32'h0, TO - 1, 32'hCAFE_F00D, 1'b0, 1'b0);
      do_access("lw_buserr",  1'b0, 1'b1, 3'b010, 32'h308, 32'h0, 1, 32'hCAFE_F00D, 1'b1, 1'b0);
      do_access("sw_timeout", 1'b1, 1'b0, 3'b111, 32'h30C, 32'h1, 9, 32'h0, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid_access();
      rd_en = 1'b1; wr_en = 1'b0; mem_acc_mode = 3'b010; addr = 32'h40; bus_ack = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      n_tests++;
      if (bus_req !== 1'b1) begin
         n_fail++; $display("FAIL rst_mid pre: got req=%b exp 1", bus_req);
      end
      #2 rst = 1'b0;
      #1;
      n_tests++;
      if (bus_req !== 1'b0 || stall !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid async: got req=%b stall=%b exp 0 0", bus_req, stall);
      end
      @(posedge clk); #1;
      n_tests++;
      if (bus_req !== 1'b0 || stall !== 1'b0 || bus_err !== 1'b0 || rdata !== 32'd0) begin
         n_fail++;
         $display("FAIL rst_mid held: got req=%b stall=%b err=%b rd=%h exp 0", bus_req, stall, bus_err, rdata);
      end
      rst = 1'b1;
      do_access("rst_fresh", 1'b0, 1'b1, 3'b010, 32'h40, 32'h0, 0, 32'h0BAD_F00D, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      bit wr, rd;
      for (int i = 0; i < 60; i++) begin
         wr = 1'($urandom_range(0, 1));
         rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
         do_access("rand", wr, rd, 3'($urandom_range(0, 7)), $urandom, $urandom,
                   $urandom_range(0, TO + 1), $urandom, ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) == 0));
      end
   endtask

   initial begin
      test_reset();
      test_store_word();
      test_load_byte();
      test_half();
      test_misalign();
      test_timeout_err();
      test_reset_mid_access();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
